dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, word-address bits (memory depth = 2^ADDR_W 32-bit words).
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, number of wait-state cycles inserted before the access commits (0..15).
REQ-003 SHALL use one clock; reset is asynchronous and active-low: clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 en  in  1  global enable; 0 freezes all state.
REQ-006 req_valid  in  1  initiator request valid.
REQ-007 req_ready  out  1  responder accepts request.
REQ-008 req_we  in  1  1 = store, 0 = load.
REQ-009 req_addr  in  32  byte address.
REQ-010 req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
REQ-011 req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
REQ-012 req_wdata  in  32  store data, LSB-aligned.
REQ-013 rsp_valid  out  1  response valid.
REQ-014 rsp_ready  in  1  initiator accepts response.
REQ-015 rsp_rdata  out  32  extended load data; 0 for stores and errors.
REQ-016 rsp_err  out  1  misaligned, out-of-range or illegal-size request.

Function
REQ-017 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-018 In IDLE, req_ready SHALL equal en. Request accepted when req_valid & req_ready; all request fields latched that cycle.
REQ-019 On accept, error SHALL be computed: size 11; half with addr[0]=1; word with addr[1:0]!=0; word index addr[31:2] >= 2^ADDR_W.
REQ-020 On accept: error -> RESP with rsp_err=1, no memory write. WAIT_CYCLES=0 -> commit, then RESP. Otherwise -> WAIT with counter loaded to WAIT_CYCLES-1.
REQ-021 In WAIT, the counter SHALL decrement each enabled cycle. At 0, access commits and FSM -> RESP. Accept-to-rsp_valid latency is WAIT_CYCLES+1 cycles.
REQ-022 Store commit SHALL write only the addressed byte lanes: byte -> lane addr[1:0] gets wdata[7:0]; half -> lanes addr[1]*2+{0,1} get wdata[15:0]; word -> all four lanes.
REQ-023 Load commit SHALL extract the addressed lane(s), right-align them, extend per req_unsigned (ignored for word), and register the result into rsp_rdata.
REQ-024 In RESP: rsp_valid=1. rsp_rdata and rsp_err SHALL be held stable until rsp_valid & rsp_ready. Handshake -> IDLE next cycle, rsp_valid=0, rsp_rdata=0, rsp_err=0.
REQ-025 req_ready SHALL be 0 in WAIT and RESP. No back-to-back accept in the cycle a response completes.
REQ-026 en=0 SHALL hold state, counter and outputs; req_ready=0. No commit and no response completion while en=0.
REQ-027 Each store SHALL commit exactly once. A load following a store to the same address SHALL return the stored value.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, counter 0, req_ready=0 (while rst_n low), rsp_valid=0, rsp_rdata=0, rsp_err=0.
REQ-029 Reset during WAIT SHALL abandon the request; an uncommitted store SHALL NOT modify memory.
REQ-030 Memory contents SHALL NOT be reset.

Structure
REQ-031 Shared package dmem_pkg SHALL hold: size encodings (SZ_B, SZ_H, SZ_W), FSM state typedef, WAIT_CYCLES maximum.
REQ-032 Memory SHALL be a sub-module dmem_byte_lane_ram: 4 byte lanes, synchronous write with 4-bit lane enable, combinational read.

Verification
REQ-033 Store word 0xDEADBEEF at 0x10, then load word at 0x10 -> rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid 2 cycles after accept (WAIT_CYCLES=1).
REQ-034 After REQ-033, load byte signed at 0x13 -> 0xFFFFFFDE. Load half unsigned at 0x12 -> 0x0000DEAD.
REQ-035 Store byte 0x55 at 0x11, then load word 0x10 -> 0xDEAD55EF.
REQ-036 Load half at 0x11, and store word at 0x1000 with ADDR_W=10 -> rsp_err=1, rsp_rdata=0; memory unchanged on re-read.
REQ-037 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_rdata stable, req_ready=0. Pulse en=0 during WAIT -> latency extended by the en-low cycles.
REQ-038 Assert rst_n=0 during WAIT of a store to 0x20 (old value 0) -> outputs zero immediately; later load 0x20 -> 0.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared size encodings, FSM state type and lane-mask helper for dmem_responder
package dmem_pkg;
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam int WAIT_MAX = 15;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;
  // Byte lanes touched by an aligned access of the given size at byte offset a
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] a);
    return size == SZ_W ? 4'hf : size == SZ_H ? (a[1] ? 4'hc : 4'h3) : 4'b0001 << a;
  endfunction
endpackage

// File: rtl/dmem_byte_lane_ram.sv
// dmem_byte_lane_ram: 2^ADDR_W x 32-bit RAM built from four byte lanes
//   clk   - write clock
//   we    - per-lane write enable, synchronous
//   addr  - word address, shared by read and write
//   wdata - write data, lane l takes wdata[8l+7:8l]
//   rdata - combinational read data
module dmem_byte_lane_ram #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic [3:0]        we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);
  for (genvar l = 0; l < 4; l++) begin : g_lane
    logic [7:0] lane [2**ADDR_W];
    always_ff @(posedge clk)
      if (we[l]) lane[addr] <= wdata[8*l +: 8];
    assign rdata[8*l +: 8] = lane[addr];
  end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: valid/ready data-memory slave with wait states, byte/half/word access and error reporting
//   clk, rst_n            - clock, asynchronous active-low reset
//   en                    - global enable, 0 freezes everything
//   req_valid/req_ready   - request handshake; req_we, req_addr, req_size, req_unsigned, req_wdata fields
//   rsp_valid/rsp_ready   - response handshake; rsp_rdata extended load data, rsp_err request error
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic we_q, we_d, uns_q, uns_d, err_q, err_d;
  logic [1:0] size_q, size_d;
  logic [ADDR_W+1:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic idle, accept, req_err, commit, cur_we, cur_uns;
  logic [1:0] cur_size;
  logic [ADDR_W+1:0] cur_addr;
  logic [31:0] cur_wdata, mem_wdata, mem_rdata, load_val;
  logic [3:0] mem_we;
  logic [7:0] ld_b;
  logic [15:0] ld_h;
  assign idle      = state_q == ST_IDLE;
  assign req_ready = en & rst_n & idle;
  assign accept    = req_valid & req_ready;
  assign req_err   = (req_size == 2'b11) | (req_size == SZ_H & req_addr[0]) |
                     (req_size == SZ_W & |req_addr[1:0]) | (|(req_addr >> (ADDR_W + 2)));
  // With zero wait states the access commits in the accept cycle straight from the request bus
  assign cur_we    = idle ? req_we : we_q;
  assign cur_uns   = idle ? req_unsigned : uns_q;
  assign cur_size  = idle ? req_size : size_q;
  assign cur_addr  = idle ? req_addr[ADDR_W+1:0] : addr_q;
  assign cur_wdata = idle ? req_wdata : wdata_q;
  assign ld_b      = mem_rdata[{cur_addr[1:0], 3'b000} +: 8];
  assign ld_h      = mem_rdata[{cur_addr[1], 4'b0000} +: 16];
  assign load_val  = cur_we ? 32'h0 : cur_size == SZ_W ? mem_rdata :
                     cur_size == SZ_H ? {{16{~cur_uns & ld_h[15]}}, ld_h} : {{24{~cur_uns & ld_b[7]}}, ld_b};
  assign mem_wdata = cur_size == SZ_W ? cur_wdata : cur_size == SZ_H ? {2{cur_wdata[15:0]}} : {4{cur_wdata[7:0]}};
  assign commit    = en & (idle ? accept & ~req_err & (WAIT_CYCLES == 0) : state_q == ST_WAIT && cnt_q == 4'd0);
  assign mem_we    = (commit & cur_we) ? lane_mask(cur_size, cur_addr[1:0]) : 4'h0;
  assign rsp_valid = state_q == ST_RESP;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  dmem_byte_lane_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk(clk), .we(mem_we), .addr(cur_addr[ADDR_W+1:2]), .wdata(mem_wdata), .rdata(mem_rdata)
  );
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    uns_d   = uns_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    if (en)
      case (state_q)
        ST_IDLE:
          if (accept) begin
            we_d    = req_we;
            uns_d   = req_unsigned;
            size_d  = req_size;
            addr_d  = req_addr[ADDR_W+1:0];
            wdata_d = req_wdata;
            if (req_err) begin
              state_d = ST_RESP;
              err_d   = 1'b1;
              rdata_d = 32'h0;
            end else if (WAIT_CYCLES == 0) begin
              state_d = ST_RESP;
              rdata_d = load_val;
            end else begin
              state_d = ST_WAIT;
              cnt_d   = 4'(WAIT_CYCLES - 1);
            end
          end
        ST_WAIT:
          if (cnt_q == 4'd0) begin
            state_d = ST_RESP;
            rdata_d = load_val;
          end else cnt_d = cnt_q - 4'd1;
        ST_RESP:
          if (rsp_ready) begin
            state_d = ST_IDLE;
            rdata_d = 32'h0;
            err_d   = 1'b0;
          end
        default: state_d = ST_IDLE;
      endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= SZ_B;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      uns_q   <= uns_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed self-checking bench for dmem_responder (ADDR_W=10, WAIT_CYCLES=1)
module tb_dmem_responder;
  logic clk = 0, rst_n = 0, en = 1, req_valid = 0, req_we = 0, req_unsigned = 0, rsp_ready = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic [1:0] req_size = 0;
  logic req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );
  task automatic drive(input logic we, input logic [31:0] a, input logic [1:0] sz, input logic u, input logic [31:0] wd);
    @(negedge clk);
    req_valid = 1; req_we = we; req_addr = a; req_size = sz; req_unsigned = u; req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
  endtask
  // Runs one full transaction; lat counts cycles from accept to rsp_valid, -1 on timeout
  task automatic txn(input logic we, input logic [31:0] a, input logic [1:0] sz, input logic u,
                     input logic [31:0] wd, output int lat, output logic [31:0] rd, output logic er);
    drive(we, a, sz, u, wd);
    lat = 1;
    while (!rsp_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) lat = -1;
    rd = rsp_rdata;
    er = rsp_err;
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
  endtask
  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready got %b want 0", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rsp_rdata got %h want 0", rsp_rdata); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err got %b want 0", rsp_err); end
    rst_n = 1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL idle_req_ready got %b want 1", req_ready); end
  endtask
  task automatic test_word;
    int lat; logic [31:0] rd; logic er;
    txn(1, 32'h10, 2'b10, 0, 32'hDEADBEEF, lat, rd, er);
    checks++; if (lat !== 2) begin errors++; $display("FAIL st_word_latency got %0d want 2", lat); end
    checks++; if (rd !== 32'h0 || er !== 1'b0) begin errors++; $display("FAIL st_word_rsp got %h/%b want 0/0", rd, er); end
    txn(0, 32'h10, 2'b10, 0, 32'h0, lat, rd, er);
    checks++; if (lat !== 2) begin errors++; $display("FAIL ld_word_latency got %0d want 2", lat); end
    checks++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin errors++; $display("FAIL ld_word got %h/%b want deadbeef/0", rd, er); end
    checks++; if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0) begin errors++; $display("FAIL post_hs got %b/%h want 0/0", rsp_valid, rsp_rdata); end
  endtask
  task automatic test_subword;
    int lat; logic [31:0] rd; logic er;
    txn(0, 32'h13, 2'b00, 0, 0, lat, rd, er);
    checks++; if (rd !== 32'hFFFFFFDE) begin errors++; $display("FAIL ld_b_signed got %h want ffffffde", rd); end
    txn(0, 32'h13, 2'b00, 1, 0, lat, rd, er);
    checks++; if (rd !== 32'h000000DE) begin errors++; $display("FAIL ld_b_unsigned got %h want 000000de", rd); end
    txn(0, 32'h12, 2'b01, 1, 0, lat, rd, er);
    checks++; if (rd !== 32'h0000DEAD) begin errors++; $display("FAIL ld_h_unsigned got %h want 0000dead", rd); end
    txn(0, 32'h12, 2'b01, 0, 0, lat, rd, er);
    checks++; if (rd !== 32'hFFFFDEAD) begin errors++; $display("FAIL ld_h_signed got %h want ffffdead", rd); end
    txn(0, 32'h10, 2'b00, 0, 0, lat, rd, er);
    checks++; if (rd !== 32'hFFFFFFEF) begin errors++; $display("FAIL ld_b0_signed got %h want ffffffef", rd); end
  endtask
  task automatic test_byte_store;
    int lat; logic [31:0] rd; logic er;
    txn(1, 32'h11, 2'b00, 0, 32'hAAAAAA55, lat, rd, er);
    txn(0, 32'h10, 2'b10, 0, 0, lat, rd, er);
    checks++; if (rd !== 32'hDEAD55EF) begin errors++; $display("FAIL st_byte got %h want dead55ef", rd); end
    txn(1, 32'h14, 2'b10, 0, 32'h0, lat, rd, er);
    txn(1, 32'h16, 2'b01, 0, 32'hFFFF1234, lat, rd, er);
    txn(0, 32'h14, 2'b10, 0, 0, lat, rd, er);
    checks++; if (rd !== 32'h12340000) begin errors++; $display("FAIL st_half got %h want 12340000", rd); end
    txn(0, 32'h16, 2'b01, 0, 0, lat, rd, er);
    checks++; if (rd !== 32'h00001234) begin errors++; $display("FAIL ld_h_pos got %h want 00001234", rd); end
  endtask
  task automatic test_errors;
    int lat; logic [31:0] rd; logic er;
    txn(0, 32'h11, 2'b01, 0, 0, lat, rd, er);
    checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL err_half_misalign got %b/%h want 1/0", er, rd); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL err_latency got %0d want 1", lat); end
    txn(1, 32'h1000, 2'b10, 0, 32'h12345678, lat, rd, er);
    checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL err_range got %b/%h want 1/0", er, rd); end
    txn(1, 32'h12, 2'b10, 0, 32'h12345678, lat, rd, er);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL err_word_misalign got %b want 1", er); end
    txn(1, 32'h10, 2'b11, 0, 32'h12345678, lat, rd, er);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL err_size got %b want 1", er); end
    txn(0, 32'h10, 2'b10, 0, 0, lat, rd, er);
    checks++; if (rd !== 32'hDEAD55EF || er !== 1'b0) begin errors++; $display("FAIL err_no_write got %h/%b want dead55ef/0", rd, er); end
  endtask
  task automatic test_hold;
    int bad = 0;
    drive(0, 32'h10, 2'b10, 0, 0);
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL hold_start got %b want 1", rsp_valid); end
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEAD55EF || req_ready !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL hold_stable got %0d bad cycles want 0", bad); end
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    checks++; if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin errors++; $display("FAIL hold_release got %b/%h/%b want 0/0/0", rsp_valid, rsp_rdata, rsp_err); end
  endtask
  task automatic test_en_pulse;
    int lat, bad = 0;
    drive(0, 32'h12, 2'b01, 1, 0);
    en = 0;
    lat = 1;
    repeat (3) begin
      @(negedge clk);
      lat++;
      if (req_ready !== 1'b0 || rsp_valid !== 1'b0) bad++;
    end
    en = 1;
    while (!rsp_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL en_freeze got %0d bad cycles want 0", bad); end
    checks++; if (lat !== 5) begin errors++; $display("FAIL en_latency got %0d want 5", lat); end
    checks++; if (rsp_rdata !== 32'h0000DEAD) begin errors++; $display("FAIL en_data got %h want 0000dead", rsp_rdata); end
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
  endtask
  task automatic test_reset_wait;
    int lat; logic [31:0] rd; logic er;
    txn(1, 32'h20, 2'b10, 0, 32'h0, lat, rd, er);
    drive(1, 32'h20, 2'b10, 0, 32'hCAFEF00D);
    rst_n = 0;
    #1;
    checks++; if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin errors++; $display("FAIL rst_wait_out got %b/%b/%h/%b want 0/0/0/0", req_ready, rsp_valid, rsp_rdata, rsp_err); end
    @(negedge clk);
    rst_n = 1;
    txn(0, 32'h20, 2'b10, 0, 0, lat, rd, er);
    checks++; if (rd !== 32'h0 || lat !== 2) begin errors++; $display("FAIL rst_wait_mem got %h lat %0d want 0 lat 2", rd, lat); end
  endtask
  task automatic test_reset_resp;
    drive(0, 32'h10, 2'b10, 0, 0);
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEAD55EF) begin errors++; $display("FAIL rst_resp_pre got %b/%h want 1/dead55ef", rsp_valid, rsp_rdata); end
    rst_n = 0;
    #1;
    checks++; if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0) begin errors++; $display("FAIL rst_resp_out got %b/%h want 0/0", rsp_valid, rsp_rdata); end
    @(negedge clk);
    rst_n = 1;
  endtask
  initial begin
    test_reset;
    test_word;
    test_subword;
    test_byte_store;
    test_errors;
    test_hold;
    test_en_pulse;
    test_reset_wait;
    test_reset_resp;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
